// File: rtl/fetch_pkg.sv
// fetch_pkg: fetch FSM states, NOP encoding and default widths shared by the fetch controller
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} fetch_state_t;
  localparam int DEF_ADDR_WIDTH = 64;
  localparam int DEF_INST_WIDTH = 32;
  localparam logic [31:0] DEF_NOP_INST = 32'h00000013;
endpackage

// File: rtl/fetch_controller.sv
// fetch_controller: IF sequencer; PC_In in, req/ack instruction memory, PC_Write/IF_ID_Write enables, held Instruction/Fetch_PC/Valid out
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int INST_WIDTH = DEF_INST_WIDTH,
  parameter logic [INST_WIDTH-1:0] NOP_INST = INST_WIDTH'(DEF_NOP_INST)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] PC_In,
  input  logic                  Hazard_Stall,
  input  logic                  Flush,
  output logic                  Mem_Req,
  output logic [ADDR_WIDTH-1:0] Mem_Addr,
  input  logic                  Mem_Ack,
  input  logic [INST_WIDTH-1:0] Mem_Rdata,
  output logic                  PC_Write,
  output logic                  IF_ID_Write,
  output logic [INST_WIDTH-1:0] Instruction,
  output logic [ADDR_WIDTH-1:0] Fetch_PC,
  output logic                  Valid
);
  fetch_state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [INST_WIDTH-1:0] inst_reg;
  logic drop;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = (state == IDLE) ? (Flush ? IDLE : WAIT)
             : (state == WAIT) ? (!Mem_Ack ? WAIT : (drop | Flush) ? IDLE : HOLD)
             : (Hazard_Stall & ~Flush) ? HOLD : IDLE;
  end
  always_comb begin
    Mem_Req     = state == WAIT;
    PC_Write    = Flush | (state == HOLD & ~Hazard_Stall);
    IF_ID_Write = state == HOLD & ~Hazard_Stall & ~Flush;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      addr_reg <= '0;
      inst_reg <= NOP_INST;
      Valid    <= 1'b0;
      drop     <= 1'b0;
    end else begin
      if (state == IDLE && !Flush) addr_reg <= PC_In;
      if (state == WAIT) begin
        drop <= Mem_Ack ? 1'b0 : drop | Flush;
        if (Mem_Ack && !(drop || Flush)) begin
          inst_reg <= Mem_Rdata;
          Valid    <= 1'b1;
        end
      end
      if (state == HOLD) begin
        if (Flush) inst_reg <= NOP_INST;
        if (Flush || !Hazard_Stall) Valid <= 1'b0;
      end
    end
  assign Mem_Addr    = addr_reg;
  assign Fetch_PC    = addr_reg;
  assign Instruction = inst_reg;
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed and random checks of fetch_controller against a transaction-level model
module tb_fetch_controller;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 0, reset = 0;
  logic [63:0] PC_In = '0;
  logic Hazard_Stall = 0, Flush = 0, Mem_Ack = 0;
  logic [31:0] Mem_Rdata = '0;
  logic Mem_Req, PC_Write, IF_ID_Write, Valid;
  logic [63:0] Mem_Addr, Fetch_PC;
  logic [31:0] Instruction;
  int errors = 0, checks = 0, ifid_pulses = 0;
  logic m_pend, m_have, m_drop;
  logic [63:0] m_addr;
  logic [31:0] m_inst;

  fetch_controller dut (
    .clk(clk), .reset(reset), .PC_In(PC_In), .Hazard_Stall(Hazard_Stall), .Flush(Flush),
    .Mem_Req(Mem_Req), .Mem_Addr(Mem_Addr), .Mem_Ack(Mem_Ack), .Mem_Rdata(Mem_Rdata),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .Instruction(Instruction),
    .Fetch_PC(Fetch_PC), .Valid(Valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_have = 0; m_drop = 0; m_addr = '0; m_inst = NOP;
  endtask

  task automatic step(input logic fl, input logic st, input logic ak, input logic [31:0] rd, input logic [63:0] pc);
    Flush = fl; Hazard_Stall = st; Mem_Ack = ak; Mem_Rdata = rd; PC_In = pc;
    #1;
    check("mem_req", Mem_Req, m_pend);
    check("mem_addr", Mem_Addr, m_addr);
    check("fetch_pc", Fetch_PC, m_addr);
    check("instruction", Instruction, m_inst);
    check("valid", Valid, m_have);
    check("pc_write", PC_Write, fl | (m_have & ~st));
    check("if_id_write", IF_ID_Write, m_have & ~st & ~fl);
    if (IF_ID_Write) ifid_pulses++;
    @(posedge clk);
    if (!m_pend && !m_have) begin
      if (!fl) begin m_addr = pc; m_pend = 1; end
    end else if (m_pend) begin
      if (ak) begin
        m_pend = 0;
        if (m_drop || fl) m_drop = 0;
        else begin m_inst = rd; m_have = 1; end
      end else if (fl) m_drop = 1;
    end else begin
      if (fl) begin m_have = 0; m_inst = NOP; end
      else if (!st) m_have = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    @(negedge clk); @(negedge clk);
    check("rst_mem_req", Mem_Req, 0);
    check("rst_mem_addr", Mem_Addr, 0);
    check("rst_instruction", Instruction, NOP);
    check("rst_valid", Valid, 0);
    check("rst_pc_write", PC_Write, 0);
    Flush = 1; #1;
    check("rst_flush_pc_write", PC_Write, 1);
    check("rst_flush_if_id", IF_ID_Write, 0);
    Flush = 0;
    @(negedge clk);
    reset = 1;
    step(0, 0, 0, 0, 64'h100);
    check("first_req", Mem_Req, 1);
    check("first_addr", Mem_Addr, 64'h100);
    step(0, 0, 1, 32'h00A00093, 64'h100);
    check("zw_valid", Valid, 1);
    check("zw_inst", Instruction, 32'h00A00093);
    step(0, 0, 0, 0, 64'h104);
    check("zw_idle", Mem_Req | Valid, 0);
    step(0, 0, 0, 0, 64'h104);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 64'h999);
      check("lat_req", Mem_Req, 1);
      check("lat_addr", Mem_Addr, 64'h104);
    end
    step(0, 0, 1, 32'h12345678, 64'h999);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 64'h108);
      check("stall_inst", Instruction, 32'h12345678);
      check("stall_valid", Valid, 1);
    end
    ifid_pulses = 0;
    step(0, 0, 0, 0, 64'h108);
    check("stall_release_pulses", ifid_pulses, 1);
    step(0, 0, 0, 0, 64'h108);
    step(1, 0, 0, 0, 64'h108);
    step(0, 0, 0, 0, 64'h200);
    step(0, 0, 1, 32'hDEADBEEF, 64'h200);
    check("flush_valid", Valid, 0);
    check("flush_inst", Instruction, 32'h12345678);
    step(0, 0, 0, 0, 64'h200);
    check("flush_new_addr", Mem_Addr, 64'h200);
    step(0, 0, 1, 32'hCAFEF00D, 64'h204);
    step(1, 1, 0, 0, 64'h204);
    check("fs_inst_nop", Instruction, NOP);
    check("fs_valid", Valid, 0);
    for (int i = 0; i < 600; i++) begin
      logic fl, st, ak;
      fl = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 3) == 0);
      ak = m_pend && ($urandom_range(0, 2) == 0);
      step(fl, st, ak, $urandom, {$urandom, $urandom});
    end
    while (!(m_pend && !m_have)) step(0, 0, 0, 0, 64'h2F0);
    #2 reset = 0;
    #1;
    check("async_mem_req", Mem_Req, 0);
    check("async_mem_addr", Mem_Addr, 0);
    check("async_inst", Instruction, NOP);
    check("async_valid", Valid, 0);
    model_reset();
    @(negedge clk);
    reset = 1;
    step(0, 0, 0, 0, 64'h300);
    check("restart_req", Mem_Req, 1);
    check("restart_addr", Mem_Addr, 64'h300);
    step(0, 0, 1, 32'h00B00113, 64'h300);
    check("restart_inst", Instruction, 32'h00B00113);
    step(0, 0, 0, 0, 64'h304);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
